// File: rtl/mm_loop_sequencer_if.sv
// Index-tuple handshake between the loop sequencer and the MAC datapath.
// The sequencer drives the tuple; the datapath returns idx_ready.
interface mm_loop_sequencer_if #(
  parameter int DIM_W = 16
);
  logic             idx_valid;
  logic             idx_ready;
  logic [DIM_W-1:0] idx_i;
  logic [DIM_W-1:0] idx_j;
  logic [DIM_W-1:0] idx_k;
  logic             acc_first;
  logic             acc_last;

  modport master (
    output idx_valid,
    input  idx_ready,
    output idx_i,
    output idx_j,
    output idx_k,
    output acc_first,
    output acc_last
  );

  modport slave (
    input  idx_valid,
    output idx_ready,
    input  idx_i,
    input  idx_j,
    input  idx_k,
    input  acc_first,
    input  acc_last
  );
endinterface

// File: rtl/mm_loop_sequencer.sv
// Walks the i/j/k loop nest of C = A*B, issuing one index tuple per accepted beat.
// Every output is taken straight from a flop; the next-state logic precomputes them.
module mm_loop_sequencer #(
  parameter int DATA_W  = 32,
  parameter int DIM_W   = 16,
  parameter int MAX_DIM = 256
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [DATA_W-1:0]    cfg_m,
  input  logic [DATA_W-1:0]    cfg_k,
  input  logic [DATA_W-1:0]    cfg_n,
  mm_loop_sequencer_if.master  idx,
  output logic                 busy,
  output logic                 done_pulse,
  output logic [DATA_W-1:0]    status
);

  localparam int LW = DIM_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [LW-1:0]    dim_m_q, dim_m_d;
  logic [LW-1:0]    dim_k_q, dim_k_d;
  logic [LW-1:0]    dim_n_q, dim_n_d;
  logic [DIM_W-1:0] cnt_i_q, cnt_i_d;
  logic [DIM_W-1:0] cnt_j_q, cnt_j_d;
  logic [DIM_W-1:0] cnt_k_q, cnt_k_d;
  logic             valid_q, valid_d;
  logic             first_q, first_d;
  logic             last_q, last_d;
  logic             busy_q, busy_d;
  logic             pulse_q, pulse_d;
  logic             st_done_q, st_done_d;
  logic             st_err_q, st_err_d;
  logic             st_abort_q, st_abort_d;

  logic             last_i, last_j, last_k;
  logic             cfg_bad;
  logic [DIM_W-1:0] k_next;

  function automatic logic dim_bad(input logic [DATA_W-1:0] d);
    return (d == '0) || (d > DATA_W'(MAX_DIM));
  endfunction

  assign cfg_bad = dim_bad(cfg_m) || dim_bad(cfg_k) || dim_bad(cfg_n);
  assign last_i  = (LW'(cnt_i_q) == dim_m_q - LW'(1));
  assign last_j  = (LW'(cnt_j_q) == dim_n_q - LW'(1));
  assign last_k  = (LW'(cnt_k_q) == dim_k_q - LW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      dim_m_q    <= '0;
      dim_k_q    <= '0;
      dim_n_q    <= '0;
      cnt_i_q    <= '0;
      cnt_j_q    <= '0;
      cnt_k_q    <= '0;
      valid_q    <= 1'b0;
      first_q    <= 1'b0;
      last_q     <= 1'b0;
      busy_q     <= 1'b0;
      pulse_q    <= 1'b0;
      st_done_q  <= 1'b0;
      st_err_q   <= 1'b0;
      st_abort_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      dim_m_q    <= dim_m_d;
      dim_k_q    <= dim_k_d;
      dim_n_q    <= dim_n_d;
      cnt_i_q    <= cnt_i_d;
      cnt_j_q    <= cnt_j_d;
      cnt_k_q    <= cnt_k_d;
      valid_q    <= valid_d;
      first_q    <= first_d;
      last_q     <= last_d;
      busy_q     <= busy_d;
      pulse_q    <= pulse_d;
      st_done_q  <= st_done_d;
      st_err_q   <= st_err_d;
      st_abort_q <= st_abort_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    dim_m_d    = dim_m_q;
    dim_k_d    = dim_k_q;
    dim_n_d    = dim_n_q;
    cnt_i_d    = cnt_i_q;
    cnt_j_d    = cnt_j_q;
    cnt_k_d    = cnt_k_q;
    valid_d    = valid_q;
    first_d    = first_q;
    last_d     = last_q;
    busy_d     = busy_q;
    pulse_d    = 1'b0;
    st_done_d  = st_done_q;
    st_err_d   = st_err_q;
    st_abort_d = st_abort_q;
    k_next     = '0;

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          dim_m_d    = LW'(cfg_m);
          dim_k_d    = LW'(cfg_k);
          dim_n_d    = LW'(cfg_n);
          st_done_d  = 1'b0;
          st_err_d   = 1'b0;
          st_abort_d = 1'b0;
          if (cfg_bad) begin
            st_err_d = 1'b1;
            pulse_d  = 1'b1;
          end else begin
            state_d = RUN;
            valid_d = 1'b1;
            busy_d  = 1'b1;
            cnt_i_d = '0;
            cnt_j_d = '0;
            cnt_k_d = '0;
            first_d = 1'b1;
            last_d  = (cfg_k == DATA_W'(1));
          end
        end
      end

      RUN: begin
        if (abort) begin
          state_d    = IDLE;
          valid_d    = 1'b0;
          busy_d     = 1'b0;
          first_d    = 1'b0;
          last_d     = 1'b0;
          cnt_i_d    = '0;
          cnt_j_d    = '0;
          cnt_k_d    = '0;
          st_abort_d = 1'b1;
        end else if (valid_q && idx.idx_ready) begin
          if (last_i && last_j && last_k) begin
            state_d = DONE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            first_d = 1'b0;
            last_d  = 1'b0;
          end else begin
            // k runs fastest; the carry ripples into j, then i.
            if (last_k) begin
              k_next = '0;
              if (last_j) begin
                cnt_j_d = '0;
                cnt_i_d = cnt_i_q + DIM_W'(1);
              end else begin
                cnt_j_d = cnt_j_q + DIM_W'(1);
              end
            end else begin
              k_next = cnt_k_q + DIM_W'(1);
            end
            cnt_k_d = k_next;
            first_d = (k_next == '0);
            last_d  = (LW'(k_next) == dim_k_q - LW'(1));
          end
        end
      end

      DONE: begin
        state_d = IDLE;
        if (abort) begin
          cnt_i_d    = '0;
          cnt_j_d    = '0;
          cnt_k_d    = '0;
          st_abort_d = 1'b1;
        end else begin
          pulse_d   = 1'b1;
          st_done_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign idx.idx_valid = valid_q;
  assign idx.idx_i     = cnt_i_q;
  assign idx.idx_j     = cnt_j_q;
  assign idx.idx_k     = cnt_k_q;
  assign idx.acc_first = first_q;
  assign idx.acc_last  = last_q;
  assign busy          = busy_q;
  assign done_pulse    = pulse_q;
  assign status        = {{(DATA_W-4){1'b0}}, st_abort_q, st_err_q, st_done_q, busy_q};

endmodule

// File: tb/tb_mm_loop_sequencer.sv
// Randomized bench for mm_loop_sequencer; expected tuples come from the beat number
// decomposed into (i,j,k) by plain arithmetic.
module tb_mm_loop_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] cfg_m = '0;
  logic [31:0] cfg_k = '0;
  logic [31:0] cfg_n = '0;
  logic        busy;
  logic        done_pulse;
  logic [31:0] status;

  int n_chk = 0;
  int n_bad = 0;

  mm_loop_sequencer_if #(.DIM_W(16)) idx_bus ();

  mm_loop_sequencer #(
    .DATA_W (32),
    .DIM_W  (16),
    .MAX_DIM(256)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .cfg_m     (cfg_m),
    .cfg_k     (cfg_k),
    .cfg_n     (cfg_n),
    .idx       (idx_bus.master),
    .busy      (busy),
    .done_pulse(done_pulse),
    .status    (status)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] tuple_now();
    return 64'({idx_bus.idx_i, idx_bus.idx_j, idx_bus.idx_k});
  endfunction

  // rmode: 0 ready always, 1 ready pattern 1,0,0 repeating, 2 random ready.
  // exp_done: expected cycle (counted from the start cycle) of done_pulse, or -1.
  task automatic run_job(input int m, input int k, input int n, input int rmode,
                         input int abort_at, input bit disturb, input int exp_done);
    int          b = 0;
    int          total = m * n * k;
    bit          fin = 1'b0;
    bit          ab = 1'b0;
    bit          hold_chk = 1'b0;
    logic [63:0] held = '0;
    int          ei, ej, ek;
    cfg_m = 32'(m);
    cfg_k = 32'(k);
    cfg_n = 32'(n);
    start = 1'b1;
    idx_bus.idx_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 1; cyc <= total * 4 + 20 && !fin; cyc++) begin
      case (rmode)
        0:       idx_bus.idx_ready = 1'b1;
        1:       idx_bus.idx_ready = ((cyc - 1) % 3 == 0);
        default: idx_bus.idx_ready = 1'($urandom_range(0, 1));
      endcase
      start = disturb && (cyc == 3);
      if (disturb && cyc == 3) cfg_m = 32'(m + 1);
      if (abort_at >= 0 && b == abort_at && !ab) begin
        abort = 1'b1;
        idx_bus.idx_ready = 1'b0;
      end
      @(negedge clk);
      if (ab) begin
        check("abort_valid", 64'(idx_bus.idx_valid), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_status", 64'(status), 64'h8);
        check("abort_idx", tuple_now(), 64'd0);
        fin = 1'b1;
      end else begin
        if (hold_chk) check("hold", {15'd0, idx_bus.idx_valid, tuple_now()[47:0]}, {15'd0, 1'b1, held[47:0]});
        hold_chk = 1'b0;
        if (done_pulse) begin
          check("beats", 64'(b), 64'(total));
          if (exp_done >= 0) check("latency", 64'(cyc), 64'(exp_done));
          check("done_status", 64'(status), 64'h2);
          check("done_busy", 64'(busy), 64'd0);
          fin = 1'b1;
        end else if (idx_bus.idx_valid) begin
          if (idx_bus.idx_ready) begin
            ei = b / (n * k);
            ej = (b / k) % n;
            ek = b % k;
            check("tuple", tuple_now(), 64'({16'(ei), 16'(ej), 16'(ek)}));
            check("acc_first", 64'(idx_bus.acc_first), 64'(ek == 0));
            check("acc_last", 64'(idx_bus.acc_last), 64'(ek == k - 1));
            check("run_status", 64'(status), 64'h1);
            b++;
          end else begin
            held = tuple_now();
            hold_chk = 1'b1;
          end
        end
        if (abort) ab = 1'b1;
      end
      @(posedge clk); #1;
      abort = 1'b0;
    end
    start = 1'b0;
    if (!fin) check("timeout", 64'd0, 64'd1);
  endtask

  task automatic cfg_err_case(input logic [31:0] m, input logic [31:0] k, input logic [31:0] n);
    cfg_m = m;
    cfg_k = k;
    cfg_n = n;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("err_pulse", 64'(done_pulse), 64'd1);
    check("err_valid", 64'(idx_bus.idx_valid), 64'd0);
    check("err_status", 64'(status), 64'h4);
    @(posedge clk); #1;
    @(negedge clk);
    check("err_pulse_once", 64'(done_pulse), 64'd0);
    check("err_valid_after", 64'(idx_bus.idx_valid), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int  seen;
    int  rm, mm, kk, nn;
    idx_bus.idx_ready = 1'b1;
    #12;
    check("rst_valid", 64'(idx_bus.idx_valid), 64'd0);
    check("rst_status", 64'(status), 64'd0);
    check("rst_outs", {57'd0, busy, done_pulse, idx_bus.acc_first, idx_bus.acc_last, 3'd0}, 64'd0);
    check("rst_idx", tuple_now(), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_job(2, 3, 2, 0, -1, 1'b0, 14);
    run_job(1, 1, 1, 0, -1, 1'b0, 3);

    cfg_err_case(32'd2, 32'd0, 32'd2);
    cfg_err_case(32'd2, 32'd2, 32'd257);
    cfg_err_case(32'hFFFF_0001, 32'd1, 32'd1);

    run_job(2, 2, 2, 1, -1, 1'b0, -1);

    run_job(4, 4, 4, 0, 5, 1'b0, -1);
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (done_pulse || idx_bus.idx_valid) seen++;
    end
    check("abort_quiet", 64'(seen), 64'd0);
    @(posedge clk); #1;
    run_job(1, 1, 1, 0, -1, 1'b0, 3);

    // Abort held in IDLE masks a simultaneous start.
    cfg_m = 32'd2; cfg_k = 32'd2; cfg_n = 32'd2;
    abort = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    check("idle_abort", {62'd0, idx_bus.idx_valid, done_pulse}, 64'd0);
    check("idle_abort_status", 64'(status), 64'h2);
    @(posedge clk); #1;

    run_job(2, 2, 2, 0, -1, 1'b1, 10);

    for (int r = 0; r < 6; r++) begin
      rm = (r % 2 == 0) ? 2 : 0;
      mm = $urandom_range(1, 4);
      kk = $urandom_range(1, 4);
      nn = $urandom_range(1, 4);
      run_job(mm, kk, nn, rm, -1, 1'b0, (rm == 0) ? mm * nn * kk + 2 : -1);
    end

    // Asynchronous reset in the middle of a run.
    cfg_m = 32'd4; cfg_k = 32'd4; cfg_n = 32'd4;
    idx_bus.idx_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 64'(idx_bus.idx_valid), 64'd0);
    check("arst_outs", {62'd0, busy, done_pulse}, 64'd0);
    check("arst_status", 64'(status), 64'd0);
    check("arst_idx", tuple_now(), 64'd0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (done_pulse || idx_bus.idx_valid) seen++;
    end
    check("arst_quiet", 64'(seen), 64'd0);
    @(posedge clk); #1;
    run_job(1, 2, 1, 0, -1, 1'b0, 4);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/mm_loop_sequencer.md
Name: mm_loop_sequencer

Overview:
Compute-core front end sitting directly downstream of the AXI-Lite control register block. It consumes the start pulse and the M/K/N configuration registers, then walks the i/j/k loop nest of C[MxN] = A[MxK]·B[KxN], issuing one index tuple per accepted beat to the MAC datapath over a valid/ready handshake. It returns a status word that the register block exposes at offset 0x04.

Parameters:
DATA_W, 32, width of the cfg inputs and the status word
DIM_W, 16, width of each loop index output
MAX_DIM, 256, largest legal value of M, K or N

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle start pulse from the control register block (ctrl_reg bit 0 edge)
abort  in  1  level; forces return to idle
cfg_m  in  DATA_W  rows of A/C
cfg_k  in  DATA_W  inner dimension
cfg_n  in  DATA_W  columns of B/C
idx_valid  out  1  index tuple valid
idx_ready  in  1  datapath accepts tuple
idx_i  out  DIM_W  row index
idx_j  out  DIM_W  column index
idx_k  out  DIM_W  inner index
acc_first  out  1  tuple is k==0 (clear accumulator)
acc_last  out  1  tuple is k==K-1 (write back C[i][j])
busy  out  1  sequencer active
done_pulse  out  1  one-cycle completion strobe
status  out  DATA_W  [0] busy, [1] done (sticky), [2] cfg_err (sticky), [3] aborted (sticky), rest 0

Behaviour:
- Reset (async assert, sync release) values: state=IDLE; all outputs 0; indices 0; sticky bits 0.
- All outputs are registered; no combinational path from any input to any output.
- States: IDLE, RUN, DONE.
- IDLE, start=1, abort=0:
  - Latch cfg_m/k/n into internal M/K/N (DIM_W+1 bits).
  - Clear status[3:1].
  - If any dim == 0 or > MAX_DIM (compared on the full DATA_W value): set cfg_err, pulse done_pulse next cycle, stay in IDLE, done bit stays 0.
  - Otherwise go to RUN. idx_valid rises on the cycle after start; busy=1 from that cycle.
- RUN:
  - idx_valid=1; tuple is held stable while idx_ready=0.
  - On handshake (idx_valid & idx_ready), advance k fastest, then j, then i. k wraps K-1→0 and increments j; j wraps N-1→0 and increments i.
  - acc_first = (idx_k==0); acc_last = (idx_k==K-1); both are valid only while idx_valid.
  - Handshake on tuple (M-1,N-1,K-1): go to DONE; idx_valid=0 next cycle.
- DONE (1 cycle): done_pulse=1, busy=0, status[1] set; then IDLE.
- Total beats = M·N·K. Minimum start→done_pulse latency with idx_ready tied 1 = M·N·K + 2 cycles.
- start while RUN or DONE: ignored; latched cfg is unaffected.
- cfg changes during RUN: no effect; only the latched copy is used.
- abort=1 in RUN or DONE: next cycle state=IDLE, idx_valid=0, busy=0, indices=0, status[3] set, no done_pulse.
- abort in IDLE: start is ignored; no flags change.
- abort and start in the same cycle: abort wins.
- rst_n asserted mid-RUN: immediate return to reset values; no done_pulse.
- status[0] mirrors busy.

Test Plan:
- M=2,K=3,N=2, idx_ready=1, start pulse → 12 beats ordered (0,0,0),(0,0,1),(0,0,2),(0,1,0)…(1,1,2); acc_first on k=0, acc_last on k=2; done_pulse 14 cycles after start; status=0x2.
- M=K=N=1 → exactly one beat (0,0,0) with acc_first=acc_last=1; done_pulse; status=0x2.
- cfg_k=0, start → no idx_valid, done_pulse next cycle, status=0x4. Repeat with cfg_n=257 → status=0x4.
- M=K=N=2 with idx_ready toggling 1,0,0,1… → tuple stable while ready=0; 8 accepted beats in order; no beat duplicated or skipped.
- M=4,K=4,N=4, abort asserted after 5 handshakes → idx_valid=0 and busy=0 next cycle, status=0x8, no done_pulse. A following start with M=K=N=1 completes with status=0x2.
- Second start and cfg_m change during RUN of M=K=N=2 → still exactly 8 beats using the original dims. Async rst_n pulse mid-run → all outputs 0 immediately.
